i2c_target_regs: RTL and testbench

Register-mapped I2C target (slave) that answers the team's I2C controller on the same two-wire bus. It oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address and drives SDA open-drain for ACKs and read data. Decoded accesses go to a byte-wide register-file port with an auto-incrementing pointer. It sits between the board-level SDA/SCL pads and the local register bank.

---
 rtl/i2c_target_regs.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register-file port and auto-incrementing pointer.
// Oversamples SCL/SDA on i_clk, filters them, decodes START/STOP and serves
// write and read transfers for a single 7-bit device address.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h1D,
  parameter int         FILTER_LEN = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_data,
  output logic       o_rd_en,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_WAIT      = 4'd9
  } state_e;

  // Last count value before a differing synchronized level is accepted.
  localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);

  // Synchronizer and filter state
  logic       scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
  logic [2:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_prev_q, sda_prev_q;

  // Bus events
  logic       start_s, stop_s, scl_rise_s, scl_fall_s;

  // Protocol state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_en_q, rd_en_d;
  logic       fetch_q, fetch_d;
  logic       rw_q, rw_d;
  logic       ack_seen_q, ack_seen_d;
  logic       busy_q, busy_d;

  logic       rx_shift_s;
  logic       rx_done_s;
  logic [7:0] rx_byte_s;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= i_scl;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= i_sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Glitch filters: accept a new level after FILTER_LEN consecutive samples
  always_comb begin
    scl_flt_d = scl_flt_q;
    scl_cnt_d = 3'd0;
    sda_flt_d = sda_flt_q;
    sda_cnt_d = 3'd0;
    if (scl_sync_q != scl_flt_q) begin
      if (scl_cnt_q == FILT_LAST) begin
        scl_flt_d = scl_sync_q;
      end else begin
        scl_cnt_d = scl_cnt_q + 3'd1;
      end
    end else begin
      scl_cnt_d = 3'd0;
    end
    if (sda_sync_q != sda_flt_q) begin
      if (sda_cnt_q == FILT_LAST) begin
        sda_flt_d = sda_sync_q;
      end else begin
        sda_cnt_d = sda_cnt_q + 3'd1;
      end
    end else begin
      sda_cnt_d = 3'd0;
    end
  end

  // Filter registers plus one-cycle history used for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
      scl_cnt_q  <= 3'd0;
      sda_cnt_q  <= 3'd0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_prev_q <= scl_flt_q;
      sda_prev_q <= sda_flt_q;
    end
  end

  // Bus event decode from the filtered lines
  always_comb begin
    start_s    = scl_flt_q & scl_prev_q & sda_prev_q & ~sda_flt_q;
    stop_s     = scl_flt_q & scl_prev_q & ~sda_prev_q & sda_flt_q;
    scl_rise_s = scl_flt_q & ~scl_prev_q;
    scl_fall_s = ~scl_flt_q & scl_prev_q;
    rx_byte_s  = {shift_q[6:0], sda_flt_q};
    rx_shift_s = scl_rise_s & ((state_q == S_ADDR) | (state_q == S_REG) | (state_q == S_WDATA));
    rx_done_s  = rx_shift_s & (bit_cnt_q == 3'd7);
  end

  // Next-state and datapath logic of the transfer state machine
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = wr_en_q ? (ptr_q + 8'd1) : ptr_q;
    sda_oe_d   = sda_oe_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    fetch_d    = rd_en_q;
    rw_d       = rw_q;
    ack_seen_d = ack_seen_q;

    if (start_s) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      fetch_d    = 1'b0;
      ack_seen_d = 1'b0;
    end else if (stop_s) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      fetch_d    = 1'b0;
      ack_seen_d = 1'b0;
    end else begin
      // Shared receive shifter; the read fetch loads the same register
      if (rx_shift_s) begin
        shift_d   = rx_byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else if (fetch_q) begin
        shift_d  = i_rd_data;
        sda_oe_d = ~i_rd_data[7];
      end else begin
        shift_d = shift_q;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ADDR: begin
          if (rx_done_s) begin
            if (rx_byte_s[7:1] == DEV_ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = rx_byte_s[0];
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d = S_RDATA;
                rd_en_d = 1'b1;
              end else begin
                state_d = S_REG;
              end
            end
          end else begin
            state_d = S_ADDR_ACK;
          end
        end
        S_REG: begin
          if (rx_done_s) begin
            ptr_d   = rx_byte_s;
            state_d = S_REG_ACK;
          end else begin
            state_d = S_REG;
          end
        end
        S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_WDATA;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_WDATA: begin
          if (rx_done_s) begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_byte_s;
            state_d   = S_WDATA_ACK;
          end else begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            state_d = S_RDATA;
          end
        end
        S_RDATA_ACK: begin
          // Pointer advances past every byte sent; only an ACK fetches more
          if (scl_rise_s) begin
            ptr_d = ptr_q + 8'd1;
            if (!sda_flt_q) begin
              ack_seen_d = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end else if (scl_fall_s && ack_seen_q) begin
            ack_seen_d = 1'b0;
            rd_en_d    = 1'b1;
            bit_cnt_d  = 3'd0;
            state_d    = S_RDATA;
          end else begin
            state_d = S_RDATA_ACK;
          end
        end
        S_WAIT: begin
          state_d = S_WAIT;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Protocol state registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
      rd_en_q    <= 1'b0;
      fetch_q    <= 1'b0;
      rw_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      fetch_q    <= fetch_d;
      rw_q       <= rw_d;
      ack_seen_q <= ack_seen_d;
      busy_q     <= busy_d;
    end
  end

  assign o_sda_oe   = sda_oe_q;
  assign o_reg_addr = ptr_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd_en    = rd_en_q;
  assign o_busy     = busy_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged controller drives the bus,
// expected register-port strobes are queued as stimulus is issued and popped
// when the target produces them.
module tb_i2c_target_regs;

  localparam int Q = 10;  // quarter SCL period in i_clk cycles

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       scl_r;
  logic       sda_low;
  logic       sda_line;
  logic       o_sda_oe;
  logic [7:0] o_reg_addr;
  logic       o_wr_en;
  logic [7:0] o_wr_data;
  logic       o_rd_en;
  logic [7:0] rd_data;
  logic       o_busy;
  logic [3:0] o_state;

  logic [7:0] mem [0:255];
  wr_t        wr_exp_q [$];
  logic [7:0] rd_exp_q [$];
  int         checks;
  int         errors;

  assign sda_line = ~(sda_low | o_sda_oe);

  i2c_target_regs #(.DEV_ADDR(7'h1D), .FILTER_LEN(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl_r),
    .i_sda      (sda_line),
    .o_sda_oe   (o_sda_oe),
    .o_reg_addr (o_reg_addr),
    .o_wr_en    (o_wr_en),
    .o_wr_data  (o_wr_data),
    .o_rd_en    (o_rd_en),
    .i_rd_data  (rd_data),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Runs once per cycle at the falling edge: scoreboard pops and bank model.
  task automatic observe();
    wr_t e;
    if (o_wr_en === 1'b1 || o_rd_en === 1'b1) chk("strobe_excl", {31'd0, o_wr_en & o_rd_en}, 32'd0);
    if (o_wr_en === 1'b1) begin
      chk("wr_pending", {31'd0, wr_exp_q.size() != 0}, 32'd1);
      if (wr_exp_q.size() != 0) begin
        e = wr_exp_q.pop_front();
        chk("wr_addr", {24'd0, o_reg_addr}, {24'd0, e.addr});
        chk("wr_data", {24'd0, o_wr_data}, {24'd0, e.data});
      end
    end
    if (o_rd_en === 1'b1) begin
      chk("rd_pending", {31'd0, rd_exp_q.size() != 0}, 32'd1);
      if (rd_exp_q.size() != 0) chk("rd_addr", {24'd0, o_reg_addr}, {24'd0, rd_exp_q.pop_front()});
      rd_data = mem[o_reg_addr];
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe();
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; tick(Q);
    scl_r   = 1'b1; tick(Q);
    sda_low = 1'b1; tick(Q);
    scl_r   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; tick(Q);
    scl_r   = 1'b1; tick(Q);
    sda_low = 1'b0; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_low = ~b;   tick(Q);
    scl_r   = 1'b1; tick(2 * Q);
    scl_r   = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; tick(Q);
    scl_r   = 1'b1; tick(Q);
    b = sda_line;   tick(Q);
    scl_r   = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    scl_r   = 1'b1;
    sda_low = 1'b0;
    rd_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;

    // Reset
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_sda_oe", {31'd0, o_sda_oe}, 32'd0);
    chk("rst_reg_addr", {24'd0, o_reg_addr}, 32'd0);
    chk("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, o_wr_data}, 32'd0);
    chk("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_state", {28'd0, o_state}, 32'd0);
    chk("rst_sda_line", {31'd0, sda_line}, 32'd1);
    tick(Q);

    // Single write
    wr_exp_q.push_back('{addr: 8'h00, data: 8'hAB});
    i2c_start();
    chk("sw_state_addr", {28'd0, o_state}, 32'd1);
    chk("sw_busy", {31'd0, o_busy}, 32'd1);
    write_byte(8'h3A, ack); chk("sw_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h00, ack); chk("sw_ack_reg", {31'd0, ack}, 32'd0);
    write_byte(8'hAB, ack); chk("sw_ack_data", {31'd0, ack}, 32'd0);
    i2c_stop();
    tick(Q);
    chk("sw_busy_after", {31'd0, o_busy}, 32'd0);
    chk("sw_state_after", {28'd0, o_state}, 32'd0);
    chk("sw_wr_done", wr_exp_q.size(), 32'd0);

    // Burst with pointer wrap
    wr_exp_q.push_back('{addr: 8'hFF, data: 8'h11});
    wr_exp_q.push_back('{addr: 8'h00, data: 8'h22});
    i2c_start();
    write_byte(8'h3A, ack); chk("bw_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'hFF, ack); chk("bw_ack_reg", {31'd0, ack}, 32'd0);
    write_byte(8'h11, ack); chk("bw_ack_d0", {31'd0, ack}, 32'd0);
    write_byte(8'h22, ack); chk("bw_ack_d1", {31'd0, ack}, 32'd0);
    i2c_stop();
    tick(Q);
    chk("bw_wr_done", wr_exp_q.size(), 32'd0);
    chk("bw_ptr", {24'd0, o_reg_addr}, 32'h01);

    // Combined write-pointer / repeated START / read
    rd_exp_q.push_back(8'h10);
    rd_exp_q.push_back(8'h11);
    i2c_start();
    write_byte(8'h3A, ack); chk("cr_ack_waddr", {31'd0, ack}, 32'd0);
    write_byte(8'h10, ack); chk("cr_ack_reg", {31'd0, ack}, 32'd0);
    i2c_start();
    write_byte(8'h3B, ack); chk("cr_ack_raddr", {31'd0, ack}, 32'd0);
    read_byte(1'b0, rb); chk("cr_byte0", {24'd0, rb}, 32'h5A);
    read_byte(1'b1, rb); chk("cr_byte1", {24'd0, rb}, 32'hC3);
    chk("cr_state_wait", {28'd0, o_state}, 32'd9);
    i2c_stop();
    tick(Q);
    chk("cr_rd_done", rd_exp_q.size(), 32'd0);
    chk("cr_ptr", {24'd0, o_reg_addr}, 32'h12);
    chk("cr_state_idle", {28'd0, o_state}, 32'd0);

    // Address mismatch, then a valid write
    i2c_start();
    write_byte(8'h3C, ack); chk("mm_nack_addr", {31'd0, ack}, 32'd1);
    chk("mm_state_wait", {28'd0, o_state}, 32'd9);
    write_byte(8'h00, ack); chk("mm_nack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    tick(Q);
    chk("mm_state_idle", {28'd0, o_state}, 32'd0);
    chk("mm_ptr_kept", {24'd0, o_reg_addr}, 32'h12);
    wr_exp_q.push_back('{addr: 8'h05, data: 8'h77});
    i2c_start();
    write_byte(8'h3A, ack); chk("mv_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h05, ack); chk("mv_ack_reg", {31'd0, ack}, 32'd0);
    write_byte(8'h77, ack); chk("mv_ack_data", {31'd0, ack}, 32'd0);
    i2c_stop();
    tick(Q);
    chk("mv_wr_done", wr_exp_q.size(), 32'd0);

    // STOP after four data bits: no strobe, pointer holds the register byte
    i2c_start();
    write_byte(8'h3A, ack); chk("ps_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h20, ack); chk("ps_ack_reg", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop();
    tick(Q);
    chk("ps_state_idle", {28'd0, o_state}, 32'd0);
    chk("ps_ptr", {24'd0, o_reg_addr}, 32'h20);

    // One-cycle SDA glitch while SCL is high
    sda_low = 1'b1; tick(1);
    sda_low = 1'b0; tick(2 * Q);
    chk("gl_state_idle", {28'd0, o_state}, 32'd0);
    chk("gl_busy", {31'd0, o_busy}, 32'd0);

    // Reset while the target is driving an ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(rb_const_3a(i));
    chk("mr_ack_driven", {31'd0, o_sda_oe}, 32'd1);
    sda_low = 1'b0;
    rst = 1'b1; tick(1);
    chk("mr_sda_oe", {31'd0, o_sda_oe}, 32'd0);
    chk("mr_state", {28'd0, o_state}, 32'd0);
    chk("mr_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0; tick(Q);
    scl_r = 1'b1; tick(2 * Q);
    chk("mr_state_after", {28'd0, o_state}, 32'd0);
    chk("mr_no_strobes", wr_exp_q.size() + rd_exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic rb_const_3a(input int idx);
    logic [7:0] v;
    v = 8'h3A;
    return v[idx];
  endfunction

endmodule
